// File: rtl/acia_io_scheduler_pkg.sv
// Shared definitions for the ACIA io scheduler: source tags, drain FSM
// encoding, default pacing parameters and the round-robin pick helper.
package acia_pkg;

  localparam logic SRC_IKBD = 1'b0;
  localparam logic SRC_MIDI = 1'b1;

  localparam int DEFAULT_IN_GAP = 64;
  localparam int DEFAULT_GAP_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } drain_state_t;

  // Fair choice between the two out-FIFOs: a lone requester wins outright,
  // a tie goes to whichever source did not transfer last.
  function automatic logic rr_pick(input logic ikbd_avail,
                                   input logic midi_avail,
                                   input logic last_src);
    if (ikbd_avail && midi_avail) return ~last_src;
    return midi_avail ? SRC_MIDI : SRC_IKBD;
  endfunction

endpackage

// File: rtl/acia_io_scheduler_if.sv
// Byte channel between the scheduler and the io controller: the tagged
// outbound stream plus the ikbd-bound inbound byte path.
interface acia_io_scheduler_if;

  logic       io_valid;
  logic       io_ready;
  logic       io_src;
  logic [7:0] io_data;
  logic       io_in_valid;
  logic [7:0] io_in_data;
  logic       io_in_ready;

  modport master (
    output io_valid, io_src, io_data, io_in_ready,
    input  io_ready, io_in_valid, io_in_data
  );

  modport slave (
    input  io_valid, io_src, io_data, io_in_ready,
    output io_ready, io_in_valid, io_in_data
  );

endinterface

// File: rtl/acia_io_scheduler_in_pacer.sv
// Inbound pacer: one-byte holding register and gap counter that spaces
// ikbd in-FIFO writes at least IN_GAP+1 cycles apart.
module acia_in_pacer
  import acia_pkg::*;
#(
  parameter int IN_GAP = DEFAULT_IN_GAP,
  parameter int GAP_W  = DEFAULT_GAP_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_strobe,
  output logic [7:0] out_data
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IN_GAP - 1);

  logic             pending;
  logic [GAP_W-1:0] gap;

  // Accept only when nothing is held and the spacing window has elapsed.
  always_comb in_ready = !pending && (gap == '0);

  // Latch an accepted byte, write it out the next cycle, then count down the gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= 1'b0;
      gap        <= '0;
      out_strobe <= 1'b0;
      out_data   <= 8'h00;
    end else begin
      out_strobe <= 1'b0;
      if (pending) begin
        out_strobe <= 1'b1;
        pending    <= 1'b0;
        gap        <= GAP_LOAD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      if (in_valid && in_ready) begin
        out_data <= in_data;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/acia_io_scheduler.sv
// ACIA io scheduler: drains the ikbd and MIDI out-FIFOs into one tagged
// byte stream and paces inbound keyboard bytes into the ikbd in-FIFO.
// Optional build macro ACIA_SCHED_MIDI_PRIO_EN gives MIDI strict priority;
// without it the two sources are served round-robin.
module acia_io_scheduler
  import acia_pkg::*;
#(
  parameter int IN_GAP = DEFAULT_IN_GAP,
  parameter int GAP_W  = DEFAULT_GAP_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ikbd_avail,
  input  logic [7:0] ikbd_data,
  output logic       ikbd_strobe,
  input  logic       midi_avail,
  input  logic [7:0] midi_data,
  output logic       midi_strobe,
  output logic       ikbd_in_strobe,
  output logic [7:0] ikbd_in_data,
  acia_io_scheduler_if.master io
);

  drain_state_t state, next_state;
  logic         last_src;
  logic         pick;
  logic         any_avail;

  // Source selection for the next byte taken in IDLE.
  always_comb begin
    any_avail = ikbd_avail || midi_avail;
`ifdef ACIA_SCHED_MIDI_PRIO_EN
    pick = midi_avail ? SRC_MIDI : SRC_IKBD;
`else
    pick = rr_pick(ikbd_avail, midi_avail, last_src);
`endif
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Drain FSM transitions: take a byte, hold it until accepted, let avail settle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_avail)   next_state = HOLD;
      HOLD:    if (io.io_ready) next_state = GAP;
      GAP:                      next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // The byte is presented for the whole HOLD state.
  always_comb io.io_valid = (state == HOLD);

  // Latch head byte and tag, pop the chosen FIFO once, remember who went last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io.io_data  <= 8'h00;
      io.io_src   <= SRC_IKBD;
      ikbd_strobe <= 1'b0;
      midi_strobe <= 1'b0;
      last_src    <= SRC_MIDI;
    end else begin
      ikbd_strobe <= 1'b0;
      midi_strobe <= 1'b0;
      if (state == IDLE && any_avail) begin
        io.io_data  <= (pick == SRC_MIDI) ? midi_data : ikbd_data;
        io.io_src   <= pick;
        ikbd_strobe <= (pick == SRC_IKBD);
        midi_strobe <= (pick == SRC_MIDI);
      end
      if (state == HOLD && io.io_ready) begin
        last_src <= io.io_src;
      end
    end
  end

  acia_in_pacer #(
    .IN_GAP (IN_GAP),
    .GAP_W  (GAP_W)
  ) u_in_pacer (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (io.io_in_valid),
    .in_data    (io.io_in_data),
    .in_ready   (io.io_in_ready),
    .out_strobe (ikbd_in_strobe),
    .out_data   (ikbd_in_data)
  );

endmodule

// File: tb/tb_acia_io_scheduler.sv
// Self-checking bench for acia_io_scheduler: FIFO models feed the drain
// side, a scoreboard holds expected (src,data) transfers and inbound bytes.
// Honours ACIA_SCHED_MIDI_PRIO_EN for the arbitration expectations.
module tb_acia_io_scheduler;
  import acia_pkg::*;

  localparam int TB_GAP = 64;

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } xfer_t;

  typedef struct {
    logic       src_in;
    logic [7:0] data_in;
    logic       exp_src;
    logic [7:0] exp_data;
    int         exp_ik;
    int         exp_midi;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ikbd_avail, midi_avail;
  logic [7:0] ikbd_data, midi_data;
  logic       ikbd_strobe, midi_strobe;
  logic       ikbd_in_strobe;
  logic [7:0] ikbd_in_data;

  acia_io_scheduler_if io_bus ();

  acia_io_scheduler #(.IN_GAP(TB_GAP), .GAP_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ikbd_avail     (ikbd_avail),
    .ikbd_data      (ikbd_data),
    .ikbd_strobe    (ikbd_strobe),
    .midi_avail     (midi_avail),
    .midi_data      (midi_data),
    .midi_strobe    (midi_strobe),
    .ikbd_in_strobe (ikbd_in_strobe),
    .ikbd_in_data   (ikbd_in_data),
    .io             (io_bus)
  );

  always #5 clk = ~clk;

  // Out-FIFO models: the bench writes, the DUT strobes pop.
  logic [7:0] ikbd_mem [256];
  logic [7:0] midi_mem [256];
  int ikbd_wr = 0, ikbd_rd = 0, midi_wr = 0, midi_rd = 0;

  assign ikbd_avail = (ikbd_wr != ikbd_rd);
  assign midi_avail = (midi_wr != midi_rd);
  assign ikbd_data  = ikbd_mem[ikbd_rd[7:0]];
  assign midi_data  = midi_mem[midi_rd[7:0]];

  always @(posedge clk) begin
    if (ikbd_strobe) ikbd_rd <= ikbd_rd + 1;
    if (midi_strobe) midi_rd <= midi_rd + 1;
  end

  xfer_t      sb [$];
  logic [7:0] in_sb [$];
  int         xfer_cycles [$];
  int         in_cycles [$];
  int checks = 0, passed = 0, cycle = 0;
  int ik_pulses = 0, midi_pulses = 0;
  int last_in = -1000;
  logic prev_ik = 1'b0, prev_midi = 1'b0, prev_in = 1'b0;
  logic in_acc = 1'b0;
  bit   pace_chk = 1'b0;
  vec_t vecs [4];

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push_ikbd(input logic [7:0] d);
    ikbd_mem[ikbd_wr[7:0]] = d;
    ikbd_wr++;
  endtask

  task automatic push_midi(input logic [7:0] d);
    midi_mem[midi_wr[7:0]] = d;
    midi_wr++;
  endtask

  task automatic apply_stimulus(input logic s, input logic [7:0] d, input logic expect_src,
                                input logic [7:0] expect_data);
    xfer_t e;
    if (s == SRC_MIDI) push_midi(d);
    else               push_ikbd(d);
    e.src  = expect_src;
    e.data = expect_data;
    sb.push_back(e);
  endtask

  task automatic expect_xfer(input logic s, input logic [7:0] d);
    xfer_t e;
    e.src  = s;
    e.data = d;
    sb.push_back(e);
  endtask

  // Called on a negedge: handshakes are judged just before the posedge,
  // registered outputs are sampled on the following negedge.
  task automatic tick();
    xfer_t e;
    #4;
    in_acc = io_bus.io_in_valid && io_bus.io_in_ready;
    if (io_bus.io_valid && io_bus.io_ready) begin
      check_output("xfer_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_output("xfer_src", int'(io_bus.io_src), int'(e.src));
        check_output("xfer_data", int'(io_bus.io_data), int'(e.data));
      end
      xfer_cycles.push_back(cycle);
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
    if (ikbd_strobe) begin
      ik_pulses++;
      check_output("ikbd_strobe_width", int'(prev_ik), 0);
    end
    if (midi_strobe) begin
      midi_pulses++;
      check_output("midi_strobe_width", int'(prev_midi), 0);
    end
    if (ikbd_in_strobe) begin
      check_output("in_strobe_width", int'(prev_in), 0);
      check_output("in_strobe_expected", int'(in_sb.size() != 0), 1);
      if (in_sb.size() != 0) check_output("in_data", int'(ikbd_in_data), int'(in_sb.pop_front()));
      in_cycles.push_back(cycle);
      last_in = cycle;
    end else if (pace_chk && (cycle - last_in) < TB_GAP - 1) begin
      check_output("in_ready_low", int'(io_bus.io_in_ready), 0);
    end
    prev_ik   = ikbd_strobe;
    prev_midi = midi_strobe;
    prev_in   = ikbd_in_strobe;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || io_bus.io_valid) && n < budget) begin
      tick();
      n++;
    end
    check_output("drain_done", sb.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    int ik0, m0, n0, n;

    vecs[0] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 1, 0};
    vecs[1] = '{1'b1, 8'h3C, 1'b1, 8'h3C, 0, 1};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1, 0};
    vecs[3] = '{1'b1, 8'hFF, 1'b1, 8'hFF, 0, 1};

    io_bus.io_ready    = 1'b0;
    io_bus.io_in_valid = 1'b0;
    io_bus.io_in_data  = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    check_output("rst_io_valid", int'(io_bus.io_valid), 0);
    check_output("rst_io_src", int'(io_bus.io_src), 0);
    check_output("rst_io_data", int'(io_bus.io_data), 0);
    check_output("rst_ikbd_strobe", int'(ikbd_strobe), 0);
    check_output("rst_midi_strobe", int'(midi_strobe), 0);
    check_output("rst_in_strobe", int'(ikbd_in_strobe), 0);
    check_output("rst_in_data", int'(ikbd_in_data), 0);
    check_output("rst_in_ready", int'(io_bus.io_in_ready), 1);
    reset_n = 1'b1;
    tick();
    tick();

    // Single-byte vectors: latency, routing and one pop per byte
    io_bus.io_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ik0 = ik_pulses;
      m0  = midi_pulses;
      apply_stimulus(vecs[i].src_in, vecs[i].data_in, vecs[i].exp_src, vecs[i].exp_data);
      tick();
      check_output("vec_first_valid", int'(io_bus.io_valid), 1);
      wait_drain(10);
      check_output("vec_ikbd_pops", ik_pulses - ik0, vecs[i].exp_ik);
      check_output("vec_midi_pops", midi_pulses - m0, vecs[i].exp_midi);
    end

    // Both sources busy
    ik0 = ik_pulses;
    m0  = midi_pulses;
    n0  = xfer_cycles.size();
    push_ikbd(8'h11);
    push_ikbd(8'h22);
    push_midi(8'h81);
    push_midi(8'h82);
`ifdef ACIA_SCHED_MIDI_PRIO_EN
    expect_xfer(SRC_MIDI, 8'h81);
    expect_xfer(SRC_MIDI, 8'h82);
    expect_xfer(SRC_IKBD, 8'h11);
    expect_xfer(SRC_IKBD, 8'h22);
`else
    expect_xfer(SRC_IKBD, 8'h11);
    expect_xfer(SRC_MIDI, 8'h81);
    expect_xfer(SRC_IKBD, 8'h22);
    expect_xfer(SRC_MIDI, 8'h82);
`endif
    wait_drain(30);
    check_output("both_count", xfer_cycles.size() - n0, 4);
    for (int i = n0 + 1; i < xfer_cycles.size(); i++)
      check_output("both_spacing", xfer_cycles[i] - xfer_cycles[i-1], 3);
    check_output("both_ikbd_pops", ik_pulses - ik0, 2);
    check_output("both_midi_pops", midi_pulses - m0, 2);

    // Backpressure on a MIDI byte
    io_bus.io_ready = 1'b0;
    m0 = midi_pulses;
    apply_stimulus(SRC_MIDI, 8'h90, SRC_MIDI, 8'h90);
    tick();
    for (int i = 0; i < 10; i++) begin
      check_output("bp_valid", int'(io_bus.io_valid), 1);
      check_output("bp_data", int'(io_bus.io_data), 8'h90);
      tick();
    end
    io_bus.io_ready = 1'b1;
    tick();
    check_output("bp_done", sb.size(), 0);
    check_output("bp_valid_drop", int'(io_bus.io_valid), 0);
    check_output("bp_midi_pops", midi_pulses - m0, 1);
    tick();
    tick();

    // Single source ikbd burst
    m0  = midi_pulses;
    ik0 = ik_pulses;
    for (int i = 0; i < 4; i++) apply_stimulus(SRC_IKBD, 8'hF0 + 8'(i), SRC_IKBD, 8'hF0 + 8'(i));
    wait_drain(40);
    check_output("single_ikbd_pops", ik_pulses - ik0, 4);
    check_output("single_midi_pops", midi_pulses - m0, 0);

    // Inbound pacing, with a concurrent outbound byte
    pace_chk = 1'b1;
    n0 = in_cycles.size();
    apply_stimulus(SRC_IKBD, 8'h5A, SRC_IKBD, 8'h5A);
    for (int b = 1; b <= 3; b++) begin
      io_bus.io_in_data  = 8'(b);
      io_bus.io_in_valid = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (!in_acc && n < 200);
      check_output("in_accept", int'(in_acc), 1);
      in_sb.push_back(8'(b));
    end
    io_bus.io_in_valid = 1'b0;
    n = 0;
    while (in_cycles.size() - n0 < 3 && n < 100) begin
      tick();
      n++;
    end
    check_output("in_count", in_cycles.size() - n0, 3);
    for (int i = n0 + 1; i < in_cycles.size(); i++)
      check_output("in_spacing", in_cycles[i] - in_cycles[i-1], TB_GAP + 1);
    check_output("concurrent_drain", sb.size(), 0);
    repeat (70) tick();
    pace_chk = 1'b0;

    // Reset while a byte is held and the pacer is mid-gap
    io_bus.io_ready = 1'b0;
    apply_stimulus(SRC_MIDI, 8'hC1, SRC_MIDI, 8'hC1);
    io_bus.io_in_data  = 8'h77;
    io_bus.io_in_valid = 1'b1;
    tick();
    check_output("rh_in_accept", int'(in_acc), 1);
    in_sb.push_back(8'h77);
    io_bus.io_in_valid = 1'b0;
    tick();
    check_output("rh_hold_valid", int'(io_bus.io_valid), 1);
    check_output("rh_in_ready_busy", int'(io_bus.io_in_ready), 0);
    reset_n = 1'b0;
    #1;
    check_output("rh_io_valid", int'(io_bus.io_valid), 0);
    check_output("rh_io_data", int'(io_bus.io_data), 0);
    check_output("rh_io_src", int'(io_bus.io_src), 0);
    check_output("rh_ikbd_strobe", int'(ikbd_strobe), 0);
    check_output("rh_midi_strobe", int'(midi_strobe), 0);
    check_output("rh_in_strobe", int'(ikbd_in_strobe), 0);
    check_output("rh_in_data", int'(ikbd_in_data), 0);
    check_output("rh_in_ready", int'(io_bus.io_in_ready), 1);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    io_bus.io_ready = 1'b1;
    push_ikbd(8'h44);
    push_midi(8'h55);
`ifdef ACIA_SCHED_MIDI_PRIO_EN
    expect_xfer(SRC_MIDI, 8'h55);
    expect_xfer(SRC_IKBD, 8'h44);
`else
    expect_xfer(SRC_IKBD, 8'h44);
    expect_xfer(SRC_MIDI, 8'h55);
`endif
    wait_drain(20);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
